ercm8_share_ctrl: RTL and testbench

- Round-robin scheduler that time-shares one combinational ERCM8 approximate 8x8 multiplier among NREQ requesters.
- Arbitrates valid/ready operand requests and holds a per-requester 7-bit mask configuration.
- Drives the shared multiplier through a registered operand stage and captures its product in a registered result stage with back-pressure.
- Returns each tagged 16-bit product on one shared result channel; sits between requester engines and the multiplier instance.

---
 rtl/ercm_pkg.sv | 23 ++
 rtl/ercm8_share_ctrl_arb.sv | 43 ++++
 rtl/ercm8_share_ctrl.sv | 119 +++++++++++
 tb/tb_ercm8_share_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ercm_pkg.sv
// Shared types and constants for the ERCM8 multiplier share controller.
// Holds operand/result bundle layouts used by the pipeline stages.
package ercm_pkg;

    localparam int OP_W     = 8;
    localparam int PROD_W   = 16;
    localparam int MASK_W   = 7;
    // Widest requester id supported (NREQ up to 8).
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic [OP_W-1:0]     a;
        logic [OP_W-1:0]     b;
        logic [MASK_W-1:0]   mask;
        logic [ID_MAX_W-1:0] id;
    } mul_op_t;

    typedef struct packed {
        logic [PROD_W-1:0]   p;
        logic [ID_MAX_W-1:0] id;
    } mul_res_t;

endpackage

// File: rtl/ercm8_share_ctrl_arb.sv
// Round-robin arbiter: one-hot grant searching upward from a pointer.
// Ports: clk, rst, req (vector), en -> gnt (one-hot), gnt_id, gnt_any.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_any
);

    logic [ID_W-1:0] ptr;

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (en && !gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner so it has lowest priority next.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= ID_W'((int'(gnt_id) + 1) % NREQ);
        end
    end

endmodule

// File: rtl/ercm8_share_ctrl.sv
// Time-shares one external ERCM8 multiplier among NREQ requesters.
// Ports: req_* operand handshakes, cfg_* mask writes, mul_* to/from the
// multiplier, res_* tagged product channel with back-pressure.
module ercm8_share_ctrl
    import ercm_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_vld,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    input  logic                 cfg_we,
    input  logic [ID_W-1:0]      cfg_id,
    input  logic [6:0]           cfg_mask,
    output logic [7:0]           mul_a_o,
    output logic [7:0]           mul_b_o,
    output logic [6:0]           mul_mask_o,
    input  logic [15:0]          mul_p_i,
    output logic                 res_vld,
    input  logic                 res_rdy,
    output logic [15:0]          res_dat,
    output logic [ID_W-1:0]      res_id
);

    logic [MASK_W-1:0] mask_q [NREQ];

    mul_op_t  s0_q;
    mul_op_t  op_d;
    mul_res_t s1_q;
    logic     v0;
    logic     v1;
    logic     s0_en;
    logic     s1_en;

    logic [NREQ-1:0] gnt;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_any;

    assign s1_en = !v1 || res_rdy;
    assign s0_en = !v0 || s1_en;

    // No grants while reset is asserted so req_rdy reads 0 then.
    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_vld),
        .en      (s0_en && !rst),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    assign req_rdy = gnt;

    always_comb begin
        op_d      = '0;
        op_d.a    = req_a[OP_W*int'(gnt_id) +: OP_W];
        op_d.b    = req_b[OP_W*int'(gnt_id) +: OP_W];
        op_d.mask = mask_q[gnt_id];
        op_d.id   = ID_MAX_W'(gnt_id);
    end

    // A write to the id being granted this cycle lands after the grant,
    // so that operation carries the old mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                mask_q[i] <= '0;
            end
        end else if (cfg_we && (int'(cfg_id) < NREQ)) begin
            mask_q[cfg_id] <= cfg_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0   <= 1'b0;
            s0_q <= '0;
        end else if (s0_en) begin
            v0 <= gnt_any;
            if (gnt_any) begin
                s0_q <= op_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            s1_q <= '0;
        end else if (s1_en) begin
            v1 <= v0;
            if (v0) begin
                s1_q.p  <= mul_p_i;
                s1_q.id <= s0_q.id;
            end
        end
    end

    assign mul_a_o    = s0_q.a;
    assign mul_b_o    = s0_q.b;
    assign mul_mask_o = s0_q.mask;

    assign res_vld = v1;
    assign res_dat = s1_q.p;
    assign res_id  = s1_q.id[ID_W-1:0];

    // Upper id bits exist only for wider configurations.
    logic unused_id;
    assign unused_id = ^{s1_q.id, s0_q.id};

endmodule

// File: tb/tb_ercm8_share_ctrl.sv
// Self-checking bench for ercm8_share_ctrl with a stand-in multiplier.
// Scoreboard model plus directed and random stimulus.
module tb_ercm8_share_ctrl;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req_vld = '0;
    logic [NREQ-1:0] req_rdy;
    logic [31:0]     req_a = '0;
    logic [31:0]     req_b = '0;
    logic            cfg_we = 1'b0;
    logic [ID_W-1:0] cfg_id = '0;
    logic [6:0]      cfg_mask = '0;
    logic [7:0]      mul_a;
    logic [7:0]      mul_b;
    logic [6:0]      mul_mask;
    logic [15:0]     mul_p;
    logic            res_vld;
    logic            res_rdy = 1'b1;
    logic [15:0]     res_dat;
    logic [ID_W-1:0] res_id;

    always #5 clk = ~clk;

    // Stand-in multiplier: exact product, mask folded into low bits.
    function automatic logic [15:0] mul_fn(
        input logic [7:0] a, input logic [7:0] b, input logic [6:0] m);
        return (16'(a) * 16'(b)) ^ {9'b0, m};
    endfunction

    assign mul_p = mul_fn(mul_a, mul_b, mul_mask);

    ercm8_share_ctrl #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_a      (req_a),
        .req_b      (req_b),
        .cfg_we     (cfg_we),
        .cfg_id     (cfg_id),
        .cfg_mask   (cfg_mask),
        .mul_a_o    (mul_a),
        .mul_b_o    (mul_b),
        .mul_mask_o (mul_mask),
        .mul_p_i    (mul_p),
        .res_vld    (res_vld),
        .res_rdy    (res_rdy),
        .res_dat    (res_dat),
        .res_id     (res_id)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] p;
        int          id;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          ptr_m;
    logic [6:0]  mask_m[NREQ];
    int          cyc = 0;
    int          tot_acc = 0;
    int          tot_res = 0;
    logic [15:0] log_dat[$];
    int          log_cyc[$];

    // Model: ops accepted are queued; the oldest is visible two negedges
    // after acceptance; a new op fits if fewer than two are in flight or
    // the oldest leaves this cycle.
    initial begin
        int   g;
        logic exp_v;
        logic room;
        ptr_m = 0;
        forever begin
            @(negedge clk);
            cyc++;
            chk("rdy_onehot0", 32'($onehot0(req_rdy)), 32'd1);
            if (rst) begin
                chk("rdy_in_rst", 32'(req_rdy), 32'd0);
                q.delete();
                ptr_m = 0;
                for (int i = 0; i < NREQ; i++) mask_m[i] = '0;
            end else begin
                exp_v = (q.size() > 0) && (cyc >= q[0].acc + 2);
                chk("res_vld", 32'(res_vld), 32'(exp_v));
                if (exp_v) begin
                    chk("res_dat", 32'(res_dat), 32'(q[0].p));
                    chk("res_id", 32'(res_id), 32'(q[0].id));
                end
                room = (q.size() < 2) || res_rdy;
                g = -1;
                if (room) begin
                    for (int k = 0; k < NREQ; k++) begin
                        int idx;
                        idx = (ptr_m + k) % NREQ;
                        if (g < 0 && req_vld[idx]) g = idx;
                    end
                end
                chk("req_rdy", 32'(req_rdy),
                    (g >= 0) ? (32'd1 << g) : 32'd0);
                if (res_vld && res_rdy) begin
                    tot_res++;
                    log_dat.push_back(res_dat);
                    log_cyc.push_back(cyc);
                end
                if (exp_v && res_rdy) void'(q.pop_front());
                if (g >= 0) begin
                    q.push_back('{mul_fn(req_a[8*g +: 8], req_b[8*g +: 8],
                                         mask_m[g]), g, cyc});
                    ptr_m = (g + 1) % NREQ;
                    tot_acc++;
                end
                if (cfg_we && int'(cfg_id) < NREQ) mask_m[cfg_id] = cfg_mask;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [15:0] rr_exp[4] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
    logic [3:0]  rr_gnt[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        logic [15:0]     sd;
        logic [ID_W-1:0] si;
        int              nlog;
        int              acc0;
        int              res0;
        logic [NREQ-1:0] hs;

        repeat (2) tick();
        rst = 1'b0;

        // Single request from requester 0.
        req_a[7:0] = 8'h01;
        req_b[7:0] = 8'hA5;
        req_vld    = 4'b0001;
        @(negedge clk);
        chk("t1_rdy", 32'(req_rdy), 32'h1);
        tick();
        req_vld = '0;
        @(posedge clk);
        @(negedge clk);
        chk("t1_vld", 32'(res_vld), 32'd1);
        chk("t1_dat", 32'(res_dat), 32'h00A5);
        chk("t1_id", 32'(res_id), 32'd0);

        // Round-robin over all four requesters.
        reset_dut();
        for (int i = 0; i < NREQ; i++) begin
            req_a[8*i +: 8] = 8'h10;
            req_b[8*i +: 8] = 8'(i + 1);
        end
        log_dat.delete();
        log_cyc.delete();
        req_vld = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_gnt", 32'(req_rdy), 32'(rr_gnt[k]));
            tick();
        end
        req_vld = '0;
        repeat (4) tick();
        chk("rr_count", 32'(log_dat.size()), 32'd5);
        for (int k = 0; k < 4; k++) begin
            chk("rr_dat", 32'(log_dat[k]), 32'(rr_exp[k]));
            chk("rr_rate", 32'(log_cyc[k+1] - log_cyc[k]), 32'd1);
        end

        // Back-pressure for five cycles after the first result.
        req_vld = 4'hF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (res_vld) break;
        end
        chk("bp_wait", 32'(res_vld), 32'd1);
        tick();
        res_rdy = 1'b0;
        @(negedge clk);
        sd   = res_dat;
        si   = res_id;
        nlog = log_dat.size();
        chk("bp_vld", 32'(res_vld), 32'd1);
        chk("bp_rdy0", 32'(req_rdy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            chk("bp_dat", 32'(res_dat), 32'(sd));
            chk("bp_id", 32'(res_id), 32'(si));
            chk("bp_rdy", 32'(req_rdy), 32'd0);
        end
        chk("bp_nolog", 32'(log_dat.size()), 32'(nlog));
        tick();
        res_rdy = 1'b1;
        repeat (2) tick();
        req_vld = '0;
        repeat (6) tick();

        // Mask write colliding with a grant to the same id.
        reset_dut();
        req_a[23:16] = 8'h03;
        req_b[23:16] = 8'h05;
        req_vld  = 4'b0100;
        cfg_we   = 1'b1;
        cfg_id   = 2'd2;
        cfg_mask = 7'h55;
        @(negedge clk);
        chk("cfg_rdy", 32'(req_rdy), 32'h4);
        tick();
        cfg_we = 1'b0;
        @(negedge clk);
        chk("cfg_old_mask", 32'(mul_mask), 32'h00);
        chk("cfg_a", 32'(mul_a), 32'h03);
        tick();
        req_vld = '0;
        @(negedge clk);
        chk("cfg_new_mask", 32'(mul_mask), 32'h55);
        repeat (4) tick();

        // Reset with both stages full.
        res_rdy = 1'b0;
        req_vld = 4'hF;
        repeat (4) tick();
        @(negedge clk);
        chk("rm_full", 32'(res_vld), 32'd1);
        tick();
        rst     = 1'b1;
        req_vld = 4'b1010;
        @(negedge clk);
        chk("rm_rdy_rst", 32'(req_rdy), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rm_vld0", 32'(res_vld), 32'd0);
        chk("rm_first", 32'(req_rdy), 32'h2);
        tick();
        req_vld = '0;
        res_rdy = 1'b1;
        repeat (4) tick();

        // Random regression.
        acc0 = tot_acc;
        res0 = tot_res;
        hs   = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_vld[i] && hs[i]) req_vld[i] = 1'b0;
                if (!req_vld[i] && ($urandom_range(2) == 0)) begin
                    req_a[8*i +: 8] = 8'($urandom);
                    req_b[8*i +: 8] = 8'($urandom);
                    req_vld[i] = 1'b1;
                end
            end
            res_rdy  = ($urandom_range(3) != 0);
            cfg_we   = ($urandom_range(7) == 0);
            cfg_id   = ID_W'($urandom);
            cfg_mask = 7'($urandom);
            @(negedge clk);
            hs = req_rdy & req_vld;
            tick();
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_vld[i] && hs[i]) req_vld[i] = 1'b0;
        end
        cfg_we  = 1'b0;
        res_rdy = 1'b1;
        for (int k = 0; k < 20 && req_vld != '0; k++) begin
            @(negedge clk);
            hs = req_rdy & req_vld;
            tick();
            req_vld = req_vld & ~hs;
        end
        req_vld = '0;
        repeat (6) tick();
        @(negedge clk);
        chk("rnd_idle", 32'(res_vld), 32'd0);
        chk("rnd_no_loss", 32'(tot_res - res0), 32'(tot_acc - acc0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
